// File: rtl/dot_tracer_pkg.sv
// ============================================================================
// Module      : dot_tracer_pkg
// Description : Shared types and helpers for the multi-dot bitmap tracer:
//               controller state enum, bitmap address packing and the
//               dot reset-position functions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dot_tracer_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        CLEAR  = 2'd2
    } state_t;

    // Bitmap address: X occupies the high half, Y the low half.
    // Callers cast the result down to 2*size_log2 bits.
    function automatic logic [31:0] bitmap_addr(input logic [31:0] x,
                                                input logic [31:0] y,
                                                input int unsigned size_log2);
        return (x << size_log2) | y;
    endfunction

    // Reset X of dot idx: dots spread evenly across the bitmap width
    function automatic logic [31:0] dot_reset_x(input int unsigned idx,
                                                input int unsigned num_dots,
                                                input int unsigned size_log2);
        return 32'(idx * ((32'd1 << size_log2) / num_dots));
    endfunction

    // Reset Y of every dot: vertical centre of the bitmap
    function automatic logic [31:0] dot_reset_y(input int unsigned size_log2);
        return 32'd1 << (size_log2 - 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bitmap_ram.sv
// ============================================================================
// Module      : bitmap_ram
// Description : Single-port bitmap RAM, synchronous read, read-first.
//               A write in cycle n is returned by a read issued in n+1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bitmap_ram #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 3
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    // Read-first port: dout shows the old contents on a write cycle
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= din;
        end
        dout <= r_mem[addr];
    end

endmodule

`default_nettype wire

// File: rtl/multi_dot_tracer.sv
// ============================================================================
// Module      : multi_dot_tracer
// Description : Advances NUM_DOTS bouncing dots once per frame, plotting each
//               dot's previous position into a bitmap RAM, and scans the
//               bitmap into a screen window at (ORG_X, ORG_Y).
//               Optional feature macro: MULTI_DOT_TRACER_CLEAR_EN (bitmap
//               wipe on the clear input).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_dot_tracer #(
    parameter int NUM_DOTS  = 4,
    parameter int SIZE_LOG2 = 8,
    parameter int COLOR_W   = 3,
    parameter int VEL       = 1,
    parameter int ORG_X     = 192,
    parameter int ORG_Y     = 112,
    parameter int TICK_Y    = 500
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               video_on,
    input  logic [11:0]        pixel_x,
    input  logic [11:0]        pixel_y,
    input  logic [COLOR_W-1:0] color,
    input  logic               load,
    input  logic               clear,
    output logic [COLOR_W-1:0] rgb,
    output logic               busy
);

    import dot_tracer_pkg::*;

    localparam int c_aw   = 2 * SIZE_LOG2;
    localparam int c_side = 2 ** SIZE_LOG2;
    localparam int c_iw   = (NUM_DOTS > 1) ? $clog2(NUM_DOTS) : 1;

    localparam logic [c_iw-1:0]      c_last_idx = c_iw'(NUM_DOTS - 1);
    localparam logic [SIZE_LOG2-1:0] c_vel      = SIZE_LOG2'(VEL);
    localparam logic [SIZE_LOG2-1:0] c_hi       = SIZE_LOG2'(c_side - 1 - VEL);
    localparam logic [SIZE_LOG2-1:0] c_init_y   = SIZE_LOG2'(dot_reset_y(SIZE_LOG2));
    localparam logic [11:0]          c_org_x    = 12'(ORG_X);
    localparam logic [11:0]          c_end_x    = 12'(ORG_X + c_side - 1);
    localparam logic [11:0]          c_org_y    = 12'(ORG_Y);
    localparam logic [11:0]          c_end_y    = 12'(ORG_Y + c_side - 1);
    localparam logic [11:0]          c_tick_y   = 12'(TICK_Y);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_iw-1:0]       r_idx;
    logic [c_iw-1:0]       w_idx_nxt;

    logic [SIZE_LOG2-1:0]  r_x [NUM_DOTS];
    logic [SIZE_LOG2-1:0]  r_y [NUM_DOTS];
    logic [NUM_DOTS-1:0]   r_dx;
    logic [NUM_DOTS-1:0]   r_dy;

    logic                  r_tick_match;
    logic                  w_tick_match;
    logic                  w_tick;
    logic                  w_clear_req;
    logic                  w_clear_done;

    logic [SIZE_LOG2-1:0]  w_cur_x;
    logic [SIZE_LOG2-1:0]  w_cur_y;
    logic                  w_dir_x;
    logic                  w_dir_y;
    logic [SIZE_LOG2-1:0]  w_new_x;
    logic [SIZE_LOG2-1:0]  w_new_y;

    logic                  w_in_win;
    logic                  r_win_d;
    logic [SIZE_LOG2-1:0]  w_rd_x;
    logic [SIZE_LOG2-1:0]  w_rd_y;
    logic [c_aw-1:0]       w_rd_addr;
    logic [c_aw-1:0]       w_upd_addr;

    logic                  w_we;
    logic [c_aw-1:0]       w_addr;
    logic [COLOR_W-1:0]    w_din;
    logic [COLOR_W-1:0]    w_dout;

    // Bounce rule: near the low wall go +, near the high wall go -
    function automatic logic next_dir(input logic [SIZE_LOG2-1:0] pos,
                                      input logic dir);
        if (pos <= c_vel) begin
            return 1'b1;
        end else if (pos >= c_hi) begin
            return 1'b0;
        end
        return dir;
    endfunction

    assign w_tick_match = (pixel_x == 12'd0) && (pixel_y == c_tick_y);
    assign w_tick       = w_tick_match && !r_tick_match;

`ifdef MULTI_DOT_TRACER_CLEAR_EN
    logic [c_aw-1:0] r_clr_addr;

    assign w_clear_req  = clear;
    assign w_clear_done = (r_clr_addr == {c_aw{1'b1}});

    // Wipe address counter, ascending from 0 while in CLEAR
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_clr_addr <= '0;
        end else if (r_state == CLEAR) begin
            r_clr_addr <= r_clr_addr + c_aw'(1);
        end else begin
            r_clr_addr <= '0;
        end
    end
`else
    logic w_unused_clear;

    assign w_unused_clear = clear;
    assign w_clear_req    = 1'b0;
    assign w_clear_done   = 1'b1;
`endif

    // State register, dot index and frame-tick edge detector
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_tick_match <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_tick_match <= w_tick_match;
        end
    end

    // Next state: clear beats load, load aborts an update, ticks only in IDLE
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            IDLE: begin
                if (w_clear_req) begin
                    w_state_nxt = CLEAR;
                end else if (w_tick) begin
                    w_state_nxt = UPDATE;
                    w_idx_nxt   = '0;
                end
            end
            UPDATE: begin
                if (w_clear_req) begin
                    w_state_nxt = CLEAR;
                end else if (load || (r_idx == c_last_idx)) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_idx_nxt = r_idx + c_iw'(1);
                end
            end
            CLEAR: begin
                if (w_clear_done) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Step of the dot currently selected by the update index
    always_comb begin
        w_cur_x = r_x[r_idx];
        w_cur_y = r_y[r_idx];
        w_dir_x = next_dir(w_cur_x, r_dx[r_idx]);
        w_dir_y = next_dir(w_cur_y, r_dy[r_idx]);
        w_new_x = w_dir_x ? (w_cur_x + c_vel) : (w_cur_x - c_vel);
        w_new_y = w_dir_y ? (w_cur_y + c_vel) : (w_cur_y - c_vel);
    end

    // Dot positions/directions: reset or load re-seed, UPDATE moves one dot
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_DOTS; i++) begin
                r_x[i]  <= SIZE_LOG2'(dot_reset_x(i, NUM_DOTS, SIZE_LOG2));
                r_y[i]  <= c_init_y;
                r_dx[i] <= 1'b1;
                r_dy[i] <= (i % 2 == 0);
            end
        end else if (load) begin
            for (int i = 0; i < NUM_DOTS; i++) begin
                r_x[i]  <= SIZE_LOG2'(dot_reset_x(i, NUM_DOTS, SIZE_LOG2));
                r_y[i]  <= c_init_y;
                r_dx[i] <= 1'b1;
                r_dy[i] <= (i % 2 == 0);
            end
        end else if (r_state == UPDATE) begin
            r_x[r_idx]  <= w_new_x;
            r_y[r_idx]  <= w_new_y;
            r_dx[r_idx] <= w_dir_x;
            r_dy[r_idx] <= w_dir_y;
        end
    end

    assign w_in_win  = video_on
                    && (pixel_x >= c_org_x) && (pixel_x <= c_end_x)
                    && (pixel_y >= c_org_y) && (pixel_y <= c_end_y);
    assign w_rd_x    = SIZE_LOG2'(pixel_x - c_org_x);
    assign w_rd_y    = SIZE_LOG2'(pixel_y - c_org_y);
    assign w_rd_addr = c_aw'(bitmap_addr(32'(w_rd_x), 32'(w_rd_y), SIZE_LOG2));
    assign w_upd_addr = c_aw'(bitmap_addr(32'(w_cur_x), 32'(w_cur_y), SIZE_LOG2));

    // RAM port mux: plot or wipe writes take the port, otherwise display read
    always_comb begin
        w_we   = 1'b0;
        w_addr = w_rd_addr;
        w_din  = '0;
        if (r_state == UPDATE) begin
            w_we   = 1'b1;
            w_addr = w_upd_addr;
            w_din  = color + COLOR_W'(r_idx);
        end
`ifdef MULTI_DOT_TRACER_CLEAR_EN
        else if (r_state == CLEAR) begin
            w_we   = 1'b1;
            w_addr = r_clr_addr;
        end
`endif
    end

    bitmap_ram #(
        .ADDR_W (c_aw),
        .DATA_W (COLOR_W)
    ) u_ram (
        .clk  (clk),
        .we   (w_we),
        .addr (w_addr),
        .din  (w_din),
        .dout (w_dout)
    );

    // Window flag delayed to line up with the registered RAM output
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_win_d <= 1'b0;
        end else begin
            r_win_d <= w_in_win;
        end
    end

    assign rgb  = r_win_d ? w_dout : '0;
    assign busy = (r_state != IDLE);

endmodule

`default_nettype wire
